load_store_unit: RTL and testbench

//  MEM-stage load/store sequencer between the EX/MEM pipeline register and the word-wide data memory.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// MEM-stage load/store sequencer that sits between the EX/MEM pipeline register
// and a word-wide data memory. The memory only supports full-word writes and a
// combinational word read. This block adds the following on top of it:
//   - byte, half and word loads, sign or zero extended
//   - sub-word stores, done as read-modify-write
//   - error detection for misaligned, illegal and out-of-range requests
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous, active-low reset
//   req_valid      pipeline presents a memory op
//   req_ready      high only when idle; accept = req_valid & req_ready
//   req_we         1 store, 0 load
//   req_funct3     RV32I width/sign code (B, H, W, BU, HU)
//   req_addr       byte address
//   req_wdata      right-aligned store data
//   resp_valid     one-cycle completion pulse
//   resp_rdata     extended load data (0 for stores and errors)
//   resp_err       error flag, qualified by resp_valid
//   mem_wr_rd_en   memory word write enable
//   mem_addr       word-aligned memory byte address
//   mem_write_data merged word to write
//   mem_read_data  combinational read of mem_addr
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DEPTH_WORDS = 64,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic        latch_req, capture_word;

  // Request classification, evaluated on the raw inputs at accept time
  logic req_illegal, req_misalign, req_range, req_error;

  always_comb begin
    req_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) ||
                   (req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
    req_misalign = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0]) ||
                   ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    req_range    = CHECK_RANGE && ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    req_error    = req_illegal || req_misalign || req_range;
  end

  // Load extraction straight from the memory read port, so the response can be
  // registered on the same edge that leaves RD
  logic [31:0] byte_shift, half_shift, load_data;

  always_comb begin
    byte_shift = mem_read_data >> {addr_q[1:0], 3'b000};
    half_shift = mem_read_data >> {addr_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b010:  load_data = mem_read_data;
      3'b100:  load_data = {24'h0, byte_shift[7:0]};
      3'b101:  load_data = {16'h0, half_shift[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // Store merge: the lane mask selects which bytes of the captured word are
  // replaced by the replicated store data
  logic [31:0] lane_mask, lane_data;

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
      end
    endcase
    mem_write_data = (word_q & ~lane_mask) | (lane_data & lane_mask);
  end

  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_wr_rd_en = (state_q == WR);
  assign req_ready    = (state_q == IDLE);

  // Next-state and response generation
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    latch_req    = 1'b0;
    capture_word = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          latch_req = 1'b1;
          if (req_error) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        capture_word = 1'b1;
        if (we_q) begin
          state_d = WR;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      word_q     <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      state_q    <= state_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      if (latch_req) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (capture_word) begin
        word_q <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;
  logic        memWrRdEn;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  int checks = 0;
  int errors = 0;

  // Behavioural memory attached to the DUT (word wide)
  logic [31:0] dutMem [64];
  int          writeCount = 0;
  logic [31:0] lastWrAddr;
  logic [31:0] lastWrData;

  // Reference model memory, kept as plain bytes
  logic [7:0]  refMem [256];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(64), .CHECK_RANGE(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_we(reqWe),
    .req_funct3(reqFunct3),
    .req_addr(reqAddr),
    .req_wdata(reqWdata),
    .resp_valid(respValid),
    .resp_rdata(respRdata),
    .resp_err(respErr),
    .mem_wr_rd_en(memWrRdEn),
    .mem_addr(memAddr),
    .mem_write_data(memWriteData),
    .mem_read_data(memReadData)
  );

  // Combinational read port of the attached memory
  assign memReadData = (memAddr[31:8] == 24'h0) ? dutMem[memAddr[7:2]] : 32'h0;

  // Word write port of the attached memory, plus a log of every write pulse
  always @(posedge clk) begin
    if (memWrRdEn) begin
      writeCount = writeCount + 1;
      lastWrAddr = memAddr;
      lastWrData = memWriteData;
      if (memAddr[31:8] == 24'h0) dutMem[memAddr[7:2]] = memWriteData;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refWord(input int idx);
    return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
  endfunction

  // Request-level reference: decides error/latency/data from the rules and
  // applies stores to the byte memory
  task automatic refModel(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic expErr,
                          output logic [31:0] expRdata, output int expLat,
                          output logic expWrite);
    int nBytes;
    logic [31:0] val;
    logic illegal, misalign, outRange;
    illegal  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
    misalign = ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) || (f3 == 2 && (addr % 4 != 0));
    outRange = (addr >= 32'd256);
    expErr   = illegal || misalign || outRange;
    expRdata = 32'h0;
    expWrite = 1'b0;
    nBytes   = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (expErr) begin
      expLat = 1;
    end else if (we) begin
      expWrite = 1'b1;
      expLat   = (nBytes == 4) ? 2 : 3;
      for (int k = 0; k < nBytes; k++) refMem[int'(addr) + k] = 8'((wdata >> (8 * k)) & 32'hFF);
    end else begin
      expLat = 2;
      val = 32'h0;
      for (int k = 0; k < nBytes; k++) val = val | (32'(refMem[int'(addr) + k]) << (8 * k));
      if (f3 == 0 && val[7])  val = val | 32'hFFFF_FF00;
      if (f3 == 1 && val[15]) val = val | 32'hFFFF_0000;
      expRdata = val;
    end
  endtask

  // Issue one request, follow it to its response and compare everything
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] obsRdata,
                               output logic obsErr);
    logic        expErr, expWrite, got;
    logic [31:0] expRdata;
    int          expLat, lat, waitCnt, startWrites;
    refModel(we, f3, addr, wdata, expErr, expRdata, expLat, expWrite);
    startWrites = writeCount;
    obsRdata = 32'h0;
    obsErr   = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = addr; reqWdata = wdata;
    waitCnt = 0;
    while (!reqReady && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("readyBeforeAccept", 32'(reqReady), 32'd1);
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (lat < 8 && !got) begin
      @(negedge clk);
      lat++;
      if (respValid) begin
        got = 1'b1;
      end else begin
        checkOutput("quietWhileBusy", respRdata | 32'(respErr), 32'h0);
        reqValid = 1'b1; reqWe = 1'($urandom); reqFunct3 = 3'($urandom);
        reqAddr = $urandom; reqWdata = $urandom;
      end
    end
    reqValid = 1'b0;
    checkOutput("respSeen", 32'(got), 32'd1);
    if (got) begin
      obsRdata = respRdata;
      obsErr   = respErr;
      checkOutput("latency", 32'(lat), 32'(expLat));
      checkOutput("respErr", 32'(respErr), 32'(expErr));
      checkOutput("respRdata", respRdata, expRdata);
      checkOutput("readyLowInResp", 32'(reqReady), 32'd0);
    end
    checkOutput("writeCount", 32'(writeCount - startWrites), 32'(expWrite));
    if (expWrite) begin
      checkOutput("writeAddr", lastWrAddr, {addr[31:2], 2'b00});
      checkOutput("writeData", lastWrData, refWord(int'(addr[7:2])));
    end
    @(negedge clk);
    checkOutput("pulseEnd", 32'(respValid), 32'd0);
    checkOutput("readyBack", 32'(reqReady), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, w;
    logic        er;
    int          r, wrBefore;
    logic [2:0]  f3;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      dutMem[i] = w;
      for (int k = 0; k < 4; k++) refMem[4*i+k] = 8'(w >> (8 * k));
    end

    rst = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqFunct3 = 3'b0; reqAddr = 32'h0; reqWdata = 32'h0;
    #12;
    checkOutput("rstReady", 32'(reqReady), 32'd1);
    checkOutput("rstRespValid", 32'(respValid), 32'd0);
    checkOutput("rstWrEn", 32'(memWrRdEn), 32'd0);
    checkOutput("rstMemAddr", memAddr, 32'h0);
    checkOutput("rstWriteData", memWriteData, 32'h0);
    checkOutput("rstRdata", respRdata | 32'(respErr), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Word store then load back
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    checkOutput("lwDeadbeef", rd, 32'hDEADBEEF);

    // Byte read-modify-write and sign/zero extended byte loads
    applyStimulus(1'b1, 3'b010, 32'h10, 32'h11223344, rd, er);
    applyStimulus(1'b1, 3'b000, 32'h12, 32'h000000AB, rd, er);
    checkOutput("sbMerged", lastWrData, 32'h11AB3344);
    applyStimulus(1'b0, 3'b000, 32'h12, 32'h0, rd, er);
    checkOutput("lbSigned", rd, 32'hFFFFFFAB);
    applyStimulus(1'b0, 3'b100, 32'h12, 32'h0, rd, er);
    checkOutput("lbuZero", rd, 32'h000000AB);

    // Upper half store and half loads
    applyStimulus(1'b1, 3'b010, 32'h14, 32'h55667788, rd, er);
    applyStimulus(1'b1, 3'b001, 32'h16, 32'h00008001, rd, er);
    checkOutput("shMerged", lastWrData, 32'h80017788);
    applyStimulus(1'b0, 3'b001, 32'h16, 32'h0, rd, er);
    checkOutput("lhSigned", rd, 32'hFFFF8001);
    applyStimulus(1'b0, 3'b101, 32'h16, 32'h0, rd, er);
    checkOutput("lhuZero", rd, 32'h00008001);

    // Error cases
    applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, rd, er);
    checkOutput("errLwMisalign", 32'(er), 32'd1);
    applyStimulus(1'b0, 3'b001, 32'h13, 32'h0, rd, er);
    checkOutput("errLhMisalign", 32'(er), 32'd1);
    applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, rd, er);
    checkOutput("errIllegal", 32'(er), 32'd1);
    applyStimulus(1'b1, 3'b010, 32'h100, 32'h12345678, rd, er);
    checkOutput("errRange", 32'(er), 32'd1);
    applyStimulus(1'b1, 3'b100, 32'h20, 32'h12345678, rd, er);
    checkOutput("errStoreBu", 32'(er), 32'd1);

    // Last word in range
    applyStimulus(1'b0, 3'b010, 32'hFC, 32'h0, rd, er);
    checkOutput("lastWordOk", 32'(er), 32'd0);

    // Reset during the write cycle of a byte store
    w = dutMem[8];
    wrBefore = writeCount;
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqFunct3 = 3'b000; reqAddr = 32'h21; reqWdata = 32'h000000CD;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("wrEnInWr", 32'(memWrRdEn), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("wrEnDropsAsync", 32'(memWrRdEn), 32'd0);
    checkOutput("readyAfterAbort", 32'(reqReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("noRespAfterAbort", 32'(respValid), 32'd0);
    end
    checkOutput("memUnchanged", dutMem[8], w);
    checkOutput("noWriteOnAbort", 32'(writeCount - wrBefore), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      r  = int'($urandom_range(0, 9));
      f3 = 3'($urandom_range(0, 7));
      if (r == 0) a = $urandom;
      else if (r < 6) a = $urandom_range(0, 255) & 32'hFC;
      else a = $urandom_range(0, 255);
      applyStimulus(1'($urandom), f3, a, $urandom, rd, er);
    end
    for (int i = 0; i < 64; i++) checkOutput("finalMem", dutMem[i], refWord(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
